// File: rtl/bk_acc_pkg.sv
// Shared types and constants for the Brent-Kung stream accumulator.
package bk_acc_pkg;

  localparam int unsigned ACC_WIDTH = 24;
  localparam int unsigned CNT_WIDTH = 8;
  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_e;

  // All-ones value of the given width, right-aligned in a SAT_MAX_W word.
  function automatic logic [SAT_MAX_W-1:0] sat_const(input int unsigned w);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bk_prefix_add.sv
// Combinational Brent-Kung prefix adder: up-sweep builds power-of-two group
// terms, down-sweep fills in the remaining prefixes.
module bk_prefix_add #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout
);

  localparam int unsigned LVLS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] gp;
  logic [WIDTH-1:0] pp;
  logic [WIDTH:0]   c;

  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gp = g;
    pp = p;
    for (int unsigned lvl = 0; lvl < LVLS; lvl++) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (32'd2 << lvl)) == 0) begin
          gp[i] = gp[i] | (pp[i] & gp[i - (32'd1 << lvl)]);
          pp[i] = pp[i] & pp[i - (32'd1 << lvl)];
        end
      end
    end
    // Down-sweep: node i merges with i-d, which already spans bits 0..i-d.
    for (int unsigned k = 0; k < LVLS; k++) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if ((i + 1 >= 3 * (32'd1 << (LVLS - 1 - k))) &&
            (((i + 1 - (32'd1 << (LVLS - 1 - k))) % (32'd2 << (LVLS - 1 - k))) == 0)) begin
          gp[i] = gp[i] | (pp[i] & gp[i - (32'd1 << (LVLS - 1 - k))]);
          pp[i] = pp[i] & pp[i - (32'd1 << (LVLS - 1 - k))];
        end
      end
    end
    c[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      c[i+1] = gp[i] | (pp[i] & cin);
    end
    S    = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end

endmodule

// File: rtl/bk_stream_accumulator.sv
// Packet accumulator over a valid/ready stream using bk_prefix_add.
// Define BK_ACC_SATURATE_EN for sticky saturation on carry-out instead of wrap.
module bk_stream_accumulator
  import bk_acc_pkg::*;
#(
  parameter int unsigned WIDTH   = ACC_WIDTH,
  parameter int unsigned COUNT_W = CNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_carry_cnt,
  output logic [COUNT_W-1:0] out_beat_cnt
);

  acc_state_e         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] carry_q, carry_d;
  logic [COUNT_W-1:0] beat_q, beat_d;
  logic [WIDTH-1:0]   osum_q, osum_d;
  logic [COUNT_W-1:0] ocarry_q, ocarry_d;
  logic [COUNT_W-1:0] obeat_q, obeat_d;

  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH-1:0]   sum_next;
  logic [COUNT_W-1:0] carry_next;
  logic [COUNT_W-1:0] beat_next;
  logic               accept;

`ifdef BK_ACC_SATURATE_EN
  localparam logic [SAT_MAX_W-1:0] SAT_FULL = sat_const(WIDTH);
`endif

  bk_prefix_add #(
    .WIDTH(WIDTH)
  ) u_add (
    .A   (acc_q),
    .B   (in_data),
    .cin (1'b0),
    .S   (add_sum),
    .cout(add_cout)
  );

  assign in_ready      = (state_q != HOLD);
  assign out_valid     = (state_q == HOLD);
  assign accept        = in_valid && in_ready;
  assign out_sum       = osum_q;
  assign out_carry_cnt = ocarry_q;
  assign out_beat_cnt  = obeat_q;

  always_comb begin
`ifdef BK_ACC_SATURATE_EN
    // Once at all-ones any further add carries out, so saturation is sticky.
    sum_next = add_cout ? SAT_FULL[WIDTH-1:0] : add_sum;
`else
    sum_next = add_sum;
`endif
    carry_next = (carry_q == '1) ? carry_q : carry_q + COUNT_W'(add_cout);
    beat_next  = (beat_q == '1) ? beat_q : beat_q + COUNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    beat_d   = beat_q;
    osum_d   = osum_q;
    ocarry_d = ocarry_q;
    obeat_d  = obeat_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = sum_next;
          carry_d = carry_next;
          beat_d  = beat_next;
          if (in_last) begin
            state_d  = HOLD;
            osum_d   = sum_next;
            ocarry_d = carry_next;
            obeat_d  = beat_next;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          carry_d = '0;
          beat_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      carry_q  <= '0;
      beat_q   <= '0;
      osum_q   <= '0;
      ocarry_q <= '0;
      obeat_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      beat_q   <= beat_d;
      osum_q   <= osum_d;
      ocarry_q <= ocarry_d;
      obeat_q  <= obeat_d;
    end
  end

endmodule

// File: tb/tb_bk_stream_accumulator.sv
// Scoreboard bench for bk_stream_accumulator: directed packets plus a
// randomised packet run checked against a small golden model.
module tb_bk_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sum;
  logic [7:0]  out_carry_cnt;
  logic [7:0]  out_beat_cnt;

  bk_stream_accumulator #(
    .WIDTH  (24),
    .COUNT_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry_cnt(out_carry_cnt),
    .out_beat_cnt (out_beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  carry;
    logic [7:0]  beats;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic ready_force = 1'b1;
  logic rnd_mode    = 1'b0;

  logic [23:0] m_sum   = '0;
  int unsigned m_carry = 0;
  int unsigned m_beats = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [23:0] s, input logic [7:0] c, input logic [7:0] b);
    exp_t e;
    e.sum = s; e.carry = c; e.beats = b;
    exp_q.push_back(e);
  endtask

  task automatic model_beat(input logic [23:0] d, input logic last);
    logic [24:0] t;
    t = {1'b0, m_sum} + {1'b0, d};
`ifdef BK_ACC_SATURATE_EN
    m_sum = t[24] ? 24'hFFFFFF : t[23:0];
`else
    m_sum = t[23:0];
`endif
    if (t[24] && m_carry < 255) m_carry++;
    if (m_beats < 255) m_beats++;
    if (last) begin
      push_exp(m_sum, m_carry[7:0], m_beats[7:0]);
      m_sum = '0; m_carry = 0; m_beats = 0;
    end
  endtask

  // Sole driver of out_ready; updated just after the edge the main sequence drives on.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_sum), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_carry_cnt", 32'(out_carry_cnt), 32'(e.carry));
        chk("out_beat_cnt", 32'(out_beat_cnt), 32'(e.beats));
      end
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic last);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    acc      = 1'b0;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    idle_cycles(3);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_carry", 32'(out_carry_cnt), 32'd0);
    chk("rst_out_beats", 32'(out_beat_cnt), 32'd0);
    rst = 1'b0;
    idle_cycles(1);

    // Three-beat packet, consumer always ready.
    push_exp(24'h000006, 8'd0, 8'd3);
    send_beat(24'h000001, 1'b0);
    send_beat(24'h000002, 1'b0);
    chk("no_early_valid", 32'(out_valid), 32'd0);
    send_beat(24'h000003, 1'b1);
    chk("valid_after_last", 32'(out_valid), 32'd1);
    chk("in_ready_hold", 32'(in_ready), 32'd0);
    idle_cycles(1);
    chk("valid_one_cycle", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);

    // Carry-out packet.
`ifdef BK_ACC_SATURATE_EN
    push_exp(24'hFFFFFF, 8'd1, 8'd2);
`else
    push_exp(24'h000001, 8'd1, 8'd2);
`endif
    send_beat(24'hFFFFFF, 1'b0);
    send_beat(24'h000002, 1'b1);
    idle_cycles(2);

    // Backpressure: result held while out_ready is low, next beat waits.
    ready_force = 1'b0;
    idle_cycles(1);
    push_exp(24'h000005, 8'd0, 8'd1);
    send_beat(24'h000005, 1'b1);
    in_valid = 1'b1; in_data = 24'h000007; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_sum", 32'(out_sum), 32'h000005);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      idle_cycles(1);
    end
    ready_force = 1'b1;
    idle_cycles(1);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    push_exp(24'h000007, 8'd0, 8'd1);
    send_beat(24'h000007, 1'b1);
    idle_cycles(2);

    // Reset mid-packet discards partial state.
    send_beat(24'h000100, 1'b0);
    send_beat(24'h000200, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_sum", 32'(out_sum), 32'd0);
    chk("midrst_out_carry", 32'(out_carry_cnt), 32'd0);
    chk("midrst_out_beats", 32'(out_beat_cnt), 32'd0);
    idle_cycles(1);
    rst = 1'b0;
    idle_cycles(1);
    push_exp(24'h000010, 8'd0, 8'd1);
    send_beat(24'h000010, 1'b1);
    idle_cycles(2);

    // Beat counter saturation: 301 beats of 1.
    push_exp(24'h00012D, 8'd0, 8'd255);
    for (int k = 0; k < 300; k++) send_beat(24'h000001, 1'b0);
    send_beat(24'h000001, 1'b1);
    idle_cycles(2);

    // Random packets with gaps on both sides, checked against the model.
    rnd_mode = 1'b1;
    for (int p = 0; p < 50; p++) begin
      int unsigned nb;
      nb = $urandom_range(1, 8);
      for (int unsigned b = 0; b < nb; b++) begin
        logic [23:0] d;
        d = 24'($urandom);
        if ($urandom_range(0, 3) == 0) d = d | 24'hF00000;
        idle_cycles(int'($urandom_range(0, 2)));
        model_beat(d, b == nb - 1);
        send_beat(d, b == nb - 1);
      end
    end
    rnd_mode = 1'b0;
    ready_force = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) idle_cycles(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    idle_cycles(2);
    chk("end_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
